// File: rtl/loop_nest_ctrl_pkg.sv
// Shared definitions for the loop-nest sequencer: FSM state encoding,
// event one-hot field order and default widths.
package loop_nest_ctrl_pkg;

  localparam int DEF_LOOP_ID_W   = 5;
  localparam int DEF_LOOP_ITER_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ENTER = 3'd2,
    S_ITER  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Bit positions inside the registered one-hot event vector.
  localparam int EV_INIT  = 0;
  localparam int EV_ENTER = 1;
  localparam int EV_VALID = 2;
  localparam int EV_EXIT  = 3;
  localparam int EV_DONE  = 4;
  localparam int EV_W     = 5;

endpackage

// File: rtl/loop_iter_regfile.sv
// Per-loop iteration limits and live counters, read combinationally at the
// current nest level. Only the counters are cleared by reset.
module loop_iter_regfile #(
  parameter int ID_W   = 5,
  parameter int ITER_W = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              max_we_i,
  input  logic [ID_W-1:0]   max_waddr_i,
  input  logic [ITER_W-1:0] max_wdata_i,
  input  logic              cnt_we_i,
  input  logic [ID_W-1:0]   idx_i,
  input  logic [ITER_W-1:0] cnt_wdata_i,
  output logic [ITER_W-1:0] max_rd_o,
  output logic [ITER_W-1:0] cnt_rd_o
);

  localparam int DEPTH = 1 << ID_W;

  logic [ITER_W-1:0] max_q [DEPTH];
  logic [ITER_W-1:0] cnt_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (max_we_i) max_q[max_waddr_i] <= max_wdata_i;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else if (cnt_we_i) begin
      cnt_q[idx_i] <= cnt_wdata_i;
    end
  end

  assign max_rd_o = max_q[idx_i];
  assign cnt_rd_o = cnt_q[idx_i];

endmodule

// File: rtl/loop_nest_ctrl.sv
// Loop-nest sequencer: walks the configured table of counted loops and emits
// one registered init/enter/index-valid/exit/done event per non-stalled cycle.
module loop_nest_ctrl
  import loop_nest_ctrl_pkg::*;
#(
  parameter int LOOP_ID_W   = DEF_LOOP_ID_W,
  parameter int LOOP_ITER_W = DEF_LOOP_ITER_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_loop_clear,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic                   start,
  input  logic                   stall,
  output logic [LOOP_ID_W-1:0]   loop_index,
  output logic                   loop_index_valid,
  output logic                   loop_init,
  output logic                   loop_enter,
  output logic                   loop_exit,
  output logic                   loop_ctrl_done,
  output logic                   busy
);

  localparam int DEPTH = 1 << LOOP_ID_W;
  localparam int NUM_W = LOOP_ID_W + 1;
  localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(DEPTH);

  state_e                 state_q;
  logic [LOOP_ID_W-1:0]   lvl_q;
  logic [LOOP_ID_W-1:0]   idx_q;
  logic [NUM_W-1:0]       num_loops_q;
  logic [EV_W-1:0]        ev_q;
  logic                   busy_q;

  logic [LOOP_ID_W-1:0]   inner;
  logic                   at_inner;
  logic                   cnt_lt;
  logic                   cfg_idle;
  logic                   max_we;
  logic                   cnt_we;
  logic [LOOP_ITER_W-1:0] max_rd;
  logic [LOOP_ITER_W-1:0] cnt_rd;
  logic [LOOP_ITER_W-1:0] cnt_wdata;

  // With a full table num_loops wraps to 0 in the low bits, so inner is still the last id.
  always_comb begin
    cfg_idle  = (state_q == S_IDLE);
    inner     = num_loops_q[LOOP_ID_W-1:0] - 1'b1;
    at_inner  = (lvl_q == inner);
    cnt_lt    = (cnt_rd < max_rd);
    max_we    = cfg_idle && cfg_loop_iter_v && !cfg_loop_clear && (num_loops_q < NUM_MAX);
    cnt_we    = !stall && ((state_q == S_ENTER) || ((state_q == S_ITER) && cnt_lt));
    cnt_wdata = (state_q == S_ENTER) ? '0 : cnt_rd + 1'b1;
  end

  loop_iter_regfile #(
    .ID_W   (LOOP_ID_W),
    .ITER_W (LOOP_ITER_W)
  ) u_regfile (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .max_we_i    (max_we),
    .max_waddr_i (num_loops_q[LOOP_ID_W-1:0]),
    .max_wdata_i (cfg_loop_iter),
    .cnt_we_i    (cnt_we),
    .idx_i       (lvl_q),
    .cnt_wdata_i (cnt_wdata),
    .max_rd_o    (max_rd),
    .cnt_rd_o    (cnt_rd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      lvl_q       <= '0;
      idx_q       <= '0;
      num_loops_q <= '0;
      ev_q        <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (cfg_idle) begin
        if (cfg_loop_clear)  num_loops_q <= '0;
        else if (max_we)     num_loops_q <= num_loops_q + 1'b1;
      end

      if (stall) begin
        ev_q <= '0;
      end else begin
        ev_q  <= '0;
        idx_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (start) begin
              busy_q  <= 1'b1;
              state_q <= (num_loops_q == '0) ? S_DONE : S_INIT;
            end
          end
          S_INIT: begin
            ev_q[EV_INIT] <= 1'b1;
            lvl_q         <= '0;
            state_q       <= S_ENTER;
          end
          S_ENTER: begin
            ev_q[EV_ENTER] <= 1'b1;
            idx_q          <= lvl_q;
            if (at_inner) state_q <= S_ITER;
            else          lvl_q   <= lvl_q + 1'b1;
          end
          // Outer levels re-enter the next inner loop after each advance.
          S_ITER: begin
            idx_q <= lvl_q;
            if (cnt_lt) begin
              ev_q[EV_VALID] <= 1'b1;
              if (!at_inner) begin
                lvl_q   <= lvl_q + 1'b1;
                state_q <= S_ENTER;
              end
            end else begin
              ev_q[EV_EXIT] <= 1'b1;
              if (lvl_q == '0) state_q <= S_DONE;
              else             lvl_q   <= lvl_q - 1'b1;
            end
          end
          S_DONE: begin
            ev_q[EV_DONE] <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign loop_index       = idx_q;
  assign loop_init        = ev_q[EV_INIT];
  assign loop_enter       = ev_q[EV_ENTER];
  assign loop_index_valid = ev_q[EV_VALID];
  assign loop_exit        = ev_q[EV_EXIT];
  assign loop_ctrl_done   = ev_q[EV_DONE];
  assign busy             = busy_q;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Directed, table-driven bench for loop_nest_ctrl: per-cycle vectors of
// inputs and expected event/index/busy, plus reset corner sequences.
module tb_loop_nest_ctrl;

  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_INIT  = 5'b00001;
  localparam logic [4:0] E_ENTER = 5'b00010;
  localparam logic [4:0] E_VALID = 5'b00100;
  localparam logic [4:0] E_EXIT  = 5'b01000;
  localparam logic [4:0] E_DONE  = 5'b10000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_loop_clear;
  logic        cfg_loop_iter_v;
  logic [15:0] cfg_loop_iter;
  logic        start;
  logic        stall;
  logic [4:0]  loop_index;
  logic        loop_index_valid;
  logic        loop_init;
  logic        loop_enter;
  logic        loop_exit;
  logic        loop_ctrl_done;
  logic        busy;

  typedef struct {
    logic        start;
    logic        stall;
    logic        cfgV;
    logic [15:0] cfgIter;
    logic [4:0]  ev;
    logic [4:0]  idx;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  loop_nest_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .cfg_loop_clear   (cfg_loop_clear),
    .cfg_loop_iter_v  (cfg_loop_iter_v),
    .cfg_loop_iter    (cfg_loop_iter),
    .start            (start),
    .stall            (stall),
    .loop_index       (loop_index),
    .loop_index_valid (loop_index_valid),
    .loop_init        (loop_init),
    .loop_enter       (loop_enter),
    .loop_exit        (loop_exit),
    .loop_ctrl_done   (loop_ctrl_done),
    .busy             (busy)
  );

  function automatic logic [4:0] evNow();
    return {loop_ctrl_done, loop_exit, loop_index_valid, loop_enter, loop_init};
  endfunction

  task automatic addVec(input logic st, input logic sl, input logic cv, input logic [15:0] ci,
                        input logic [4:0] ev, input logic [4:0] idx, input logic b);
    vec_t v;
    v.start = st; v.stall = sl; v.cfgV = cv; v.cfgIter = ci;
    v.ev = ev; v.idx = idx; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] expEv,
                             input logic [4:0] expIdx, input logic expBusy);
    checks++;
    if (evNow() !== expEv) begin
      errors++;
      $display("[TB] FAIL %s events: got %b want %b", name, evNow(), expEv);
    end
    if (expEv != E_NONE && expEv != E_DONE) begin
      checks++;
      if (loop_index !== expIdx) begin
        errors++;
        $display("[TB] FAIL %s loop_index: got %0d want %0d", name, loop_index, expIdx);
      end
    end
    if (expBusy !== 1'bx) begin
      checks++;
      if (busy !== expBusy) begin
        errors++;
        $display("[TB] FAIL %s busy: got %b want %b", name, busy, expBusy);
      end
    end
  endtask

  task automatic driveVec(input vec_t v);
    start           = v.start;
    stall           = v.stall;
    cfg_loop_iter_v = v.cfgV;
    cfg_loop_iter   = v.cfgIter;
  endtask

  // Each vector is driven on one negedge and its outputs checked on the next.
  task automatic applyStimulus(input string name);
    vec_t idle;
    idle.start = 0; idle.stall = 0; idle.cfgV = 0; idle.cfgIter = '0;
    idle.ev = E_NONE; idle.idx = '0; idle.busy = 1'b0;
    @(negedge clk);
    driveVec(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s[%0d]", name, i), vecs[i].ev, vecs[i].idx, vecs[i].busy);
      if (i + 1 < vecs.size()) driveVec(vecs[i+1]);
      else                     driveVec(idle);
    end
    vecs.delete();
  endtask

  task automatic clearTable();
    @(negedge clk);
    cfg_loop_clear = 1'b1;
    @(negedge clk);
    cfg_loop_clear = 1'b0;
  endtask

  task automatic addLoop(input logic [15:0] maxv);
    @(negedge clk);
    cfg_loop_iter_v = 1'b1;
    cfg_loop_iter   = maxv;
    @(negedge clk);
    cfg_loop_iter_v = 1'b0;
  endtask

  task automatic build12();
    addVec(1, 0, 0, 16'd0, E_NONE,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_INIT,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_ENTER, 5'd0, 1'b1);
    addVec(1, 0, 1, 16'd7, E_ENTER, 5'd1, 1'b1);
    addVec(0, 0, 0, 16'd0, E_VALID, 5'd1, 1'b1);
    addVec(0, 0, 1, 16'd9, E_VALID, 5'd1, 1'b1);
    addVec(0, 0, 0, 16'd0, E_EXIT,  5'd1, 1'b1);
    addVec(1, 0, 0, 16'd0, E_VALID, 5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_ENTER, 5'd1, 1'b1);
    addVec(0, 0, 0, 16'd0, E_VALID, 5'd1, 1'b1);
    addVec(0, 0, 0, 16'd0, E_VALID, 5'd1, 1'b1);
    addVec(0, 0, 0, 16'd0, E_EXIT,  5'd1, 1'b1);
    addVec(0, 0, 0, 16'd0, E_EXIT,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_DONE,  5'd0, 1'bx);
    addVec(0, 0, 0, 16'd0, E_NONE,  5'd0, 1'b0);
  endtask

  task automatic buildEmpty();
    addVec(1, 0, 0, 16'd0, E_NONE, 5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_DONE, 5'd0, 1'bx);
    addVec(0, 0, 0, 16'd0, E_NONE, 5'd0, 1'b0);
    addVec(0, 0, 0, 16'd0, E_NONE, 5'd0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; cfg_loop_clear = 1'b0; cfg_loop_iter_v = 1'b0;
    cfg_loop_iter = '0; start = 1'b0; stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", E_NONE, 5'd0, 1'b0);
    resetn = 1'b1;

    // {1,2}: mid-walk start and config attempts must be ignored, rerun identical.
    addLoop(16'd1);
    addLoop(16'd2);
    build12();
    applyStimulus("nest12");
    build12();
    applyStimulus("nest12_again");

    clearTable();
    addLoop(16'd0);
    addVec(1, 0, 0, 16'd0, E_NONE,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_INIT,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_ENTER, 5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_EXIT,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_DONE,  5'd0, 1'bx);
    addVec(0, 0, 0, 16'd0, E_NONE,  5'd0, 1'b0);
    applyStimulus("nest0");

    // Clear beats append in the same cycle, leaving an empty table.
    @(negedge clk);
    cfg_loop_clear = 1'b1; cfg_loop_iter_v = 1'b1; cfg_loop_iter = 16'd4;
    @(negedge clk);
    cfg_loop_clear = 1'b0; cfg_loop_iter_v = 1'b0;
    buildEmpty();
    applyStimulus("empty");

    addLoop(16'd3);
    addVec(1, 0, 0, 16'd0, E_NONE,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_INIT,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_ENTER, 5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_VALID, 5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_VALID, 5'd0, 1'b1);
    addVec(0, 1, 0, 16'd0, E_NONE,  5'd0, 1'b1);
    addVec(0, 1, 0, 16'd0, E_NONE,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_VALID, 5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_EXIT,  5'd0, 1'b1);
    addVec(0, 0, 0, 16'd0, E_DONE,  5'd0, 1'bx);
    addVec(0, 0, 0, 16'd0, E_NONE,  5'd0, 1'b0);
    applyStimulus("stall3");

    // Asynchronous reset while a valid(1) event is on the outputs.
    clearTable();
    addLoop(16'd1);
    addLoop(16'd2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset", E_VALID, 5'd1, 1'b1);
    #2 resetn = 1'b0;
    #1 checkOutput("async_reset", E_NONE, 5'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("post_reset", E_NONE, 5'd0, 1'b0);
    buildEmpty();
    applyStimulus("post_reset_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
